// File: rtl/teste_rede_float2_if.sv
// Sample/result bus between the neuron block, its sample source and its result sink.
// Single-cycle codes, no backpressure: req_in=1 asks the source to advance `in`, out_en=1 marks io_out new.
interface teste_rede_float2_if;
    logic signed [18:0] in;
    logic signed [27:0] io_out;
    logic [3:0]         req_in;
    logic [3:0]         out_en;

    modport master (output in, input io_out, input req_in, input out_en);
    modport slave  (input in, output io_out, output req_in, output out_en);
endinterface

// File: rtl/teste_rede_float2.sv
// Streaming single-neuron inference: 4-sample window, serial MAC, shift, ReLU, 28-bit saturation.
// One result every 8 cycles: LOAD, MAC x4, ACT, OUT, REQ.
module teste_rede_float2 #(
    parameter logic signed [18:0] W0    = 19'sd1,
    parameter logic signed [18:0] W1    = -19'sd1,
    parameter logic signed [18:0] W2    = 19'sd2,
    parameter logic signed [18:0] W3    = 19'sd1,
    parameter logic signed [39:0] BIAS  = 40'sd0,
    parameter int                 SHIFT = 0
) (
    input  logic                clk,
    input  logic                rst,
    teste_rede_float2_if.slave  bus,
    output logic [2:0]          o_dbg_state
);
    typedef enum logic [2:0] {
        S_LOAD = 3'd0,
        S_MAC  = 3'd1,
        S_ACT  = 3'd2,
        S_OUT  = 3'd3,
        S_REQ  = 3'd4
    } state_t;

    localparam logic signed [39:0] SAT_MAX = 40'sd134217727;

    state_t             r_state;
    logic signed [18:0] r_x0, r_x1, r_x2, r_x3;
    logic signed [39:0] r_acc;
    logic [1:0]         r_k;

    logic signed [18:0] w_w;
    logic signed [18:0] w_x;
    logic signed [37:0] w_prod;
    logic signed [39:0] w_shifted;
    logic [27:0]        w_act;

    always_comb begin
        w_w = W0;
        w_x = r_x0;
        case (r_k)
            2'd0: begin w_w = W0; w_x = r_x0; end
            2'd1: begin w_w = W1; w_x = r_x1; end
            2'd2: begin w_w = W2; w_x = r_x2; end
            default: begin w_w = W3; w_x = r_x3; end
        endcase
    end

    assign w_prod    = w_w * w_x;
    assign w_shifted = r_acc >>> SHIFT;

    // ReLU then clamp; the result is always non-negative so it fits 28 bits signed.
    always_comb begin
        w_act = '0;
        if (w_shifted[39])
            w_act = '0;
        else if (w_shifted > SAT_MAX)
            w_act = SAT_MAX[27:0];
        else
            w_act = w_shifted[27:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_LOAD;
            r_x0       <= '0;
            r_x1       <= '0;
            r_x2       <= '0;
            r_x3       <= '0;
            r_acc      <= '0;
            r_k        <= '0;
            bus.io_out <= '0;
            bus.req_in <= 4'd0;
            bus.out_en <= 4'd0;
        end else begin
            bus.req_in <= 4'd0;
            bus.out_en <= 4'd0;
            case (r_state)
                S_LOAD: begin
                    r_x3    <= r_x2;
                    r_x2    <= r_x1;
                    r_x1    <= r_x0;
                    r_x0    <= bus.in;
                    r_acc   <= BIAS;
                    r_k     <= 2'd0;
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    r_acc <= r_acc + {{2{w_prod[37]}}, w_prod};
                    r_k   <= r_k + 2'd1;
                    if (r_k == 2'd3)
                        r_state <= S_ACT;
                end
                S_ACT: begin
                    // Outputs are registered, so the pulse for the OUT cycle is set here.
                    bus.io_out <= w_act;
                    bus.out_en <= 4'd1;
                    r_state    <= S_OUT;
                end
                S_OUT: begin
                    bus.req_in <= 4'd1;
                    r_state    <= S_REQ;
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_teste_rede_float2.sv
// Directed bench for teste_rede_float2: default weights, a saturating weight set and a shift/bias set.
module tb_teste_rede_float2;
    logic clk;
    logic rst_a, rst_b, rst_c;
    logic [2:0] st_a, st_b, st_c;
    int vectors = 0;
    int fails   = 0;

    teste_rede_float2_if ifa ();
    teste_rede_float2_if ifb ();
    teste_rede_float2_if ifc ();

    teste_rede_float2 u_def (
        .clk(clk), .rst(rst_a), .bus(ifa.slave), .o_dbg_state(st_a)
    );
    teste_rede_float2 #(
        .W0(19'sd1000), .W1(19'sd0), .W2(19'sd0), .W3(19'sd0)
    ) u_sat (
        .clk(clk), .rst(rst_b), .bus(ifb.slave), .o_dbg_state(st_b)
    );
    teste_rede_float2 #(
        .BIAS(-40'sd8), .SHIFT(2)
    ) u_sh (
        .clk(clk), .rst(rst_c), .bus(ifc.slave), .o_dbg_state(st_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] en_of(input int d);
        case (d)
            0: return ifa.out_en;
            1: return ifb.out_en;
            default: return ifc.out_en;
        endcase
    endfunction

    function automatic logic [3:0] rq_of(input int d);
        case (d)
            0: return ifa.req_in;
            1: return ifb.req_in;
            default: return ifc.req_in;
        endcase
    endfunction

    function automatic logic [27:0] io_of(input int d);
        case (d)
            0: return ifa.io_out;
            1: return ifb.io_out;
            default: return ifc.io_out;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives one sample, waits (bounded) for the out_en pulse, checks edges/result, then the req_in pulse.
    task automatic run_sample(input int d, input logic signed [18:0] s, input int exp_edges,
                              input logic [27:0] exp_val, input string tag);
        int  n;
        logic got;
        n   = 0;
        got = 1'b0;
        case (d)
            0: ifa.in = s;
            1: ifb.in = s;
            default: ifc.in = s;
        endcase
        while (n < 16 && !got) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            check({tag, "_excl"}, {31'd0, (rq_of(d) == 4'd1 && en_of(d) == 4'd1)}, 32'd0);
            if (en_of(d) == 4'd1) got = 1'b1;
        end
        check({tag, "_edges"}, n, exp_edges);
        check({tag, "_io"}, {4'd0, io_of(d)}, {4'd0, exp_val});
        @(posedge clk);
        @(negedge clk);
        check({tag, "_req"}, {28'd0, rq_of(d)}, 32'd1);
        check({tag, "_en_low"}, {28'd0, en_of(d)}, 32'd0);
        check({tag, "_io_hold"}, {4'd0, io_of(d)}, {4'd0, exp_val});
    endtask

    initial begin
        rst_a  = 1'b0;
        rst_b  = 1'b0;
        rst_c  = 1'b0;
        ifa.in = 19'sd123;
        ifb.in = 19'sd0;
        ifc.in = 19'sd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_io",    {4'd0, ifa.io_out}, 32'd0);
        check("rst_req",   {28'd0, ifa.req_in}, 32'd0);
        check("rst_en",    {28'd0, ifa.out_en}, 32'd0);
        check("rst_state", {29'd0, st_a}, 32'd0);

        // Default weights: windows [10], [20,10], [5,20,10], [-100,5,20,10], [60,-100,5,20].
        rst_a = 1'b1;
        run_sample(0, 19'sd10,   6, 28'd10,  "s10");
        run_sample(0, 19'sd20,   7, 28'd10,  "s20");
        run_sample(0, 19'sd5,    7, 28'd5,   "s5");
        run_sample(0, -19'sd100, 7, 28'd0,   "relu");
        run_sample(0, 19'sd60,   7, 28'd190, "s60");

        // Abort during MAC: REQ edge, LOAD edge, first MAC edge.
        ifa.in = 19'sd50;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_in_mac", {29'd0, st_a}, 32'd1);
        rst_a = 1'b0;
        #1;
        check("mid_io_clr", {4'd0, ifa.io_out}, 32'd0);
        check("mid_state",  {29'd0, st_a}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_no_en", {28'd0, ifa.out_en}, 32'd0);
        end
        ifa.in = 19'sd7;
        rst_a  = 1'b1;
        run_sample(0, 19'sd7, 6, 28'd7, "after_rst");

        // W0=1000: 262143000 clamps to 2^27-1; -262144000 goes to 0.
        rst_b = 1'b1;
        run_sample(1, 19'sd262143,  6, 28'd134217727, "sat_hi");
        run_sample(1, -19'sd262144, 7, 28'd0,         "sat_lo");

        // (40 - 8) >>> 2 = 8.
        rst_c = 1'b1;
        run_sample(2, 19'sd40, 6, 28'd8, "shift_bias");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
